// File: rtl/ahb_defs.sv
// Shared AHB-lite encodings and the error-response FSM state type.
package ahb_defs;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_t;

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer: holds a write whose data phase collided with a
// read address phase, drains it later, and forwards it to matching reads.
module ahb_sram_wbuf #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic [W_ADDR-1:0]     addr_i,
    input  logic [W_DATA/8-1:0]   mask_i,
    input  logic [W_DATA-1:0]     data_i,
    output logic                  valid_o,
    output logic [W_ADDR-1:0]     addr_o,
    output logic [W_DATA/8-1:0]   mask_o,
    output logic [W_DATA-1:0]     data_o,
    input  logic [W_ADDR-1:0]     rd_addr_i,
    input  logic [W_DATA-1:0]     rd_data_i,
    output logic [W_DATA-1:0]     merged_o
);

    logic                valid_q, valid_d;
    logic [W_ADDR-1:0]   addr_q, addr_d;
    logic [W_DATA/8-1:0] mask_q, mask_d;
    logic [W_DATA-1:0]   data_q, data_d;

    // Next-state: load captures a new entry, drain empties it
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            mask_d  = mask_i;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer entry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

    // Forwarding: buffered lanes override SRAM data on an address match
    always_comb begin
        merged_o = rd_data_i;
        if (valid_q && (addr_q == rd_addr_i)) begin
            for (int unsigned i = 0; i < W_DATA / 8; i++) begin
                if (mask_q[i]) merged_o[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign mask_o  = mask_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ahb_sync_sram.sv
// AHB-lite slave in front of a 1-cycle-latency synchronous SRAM with
// zero-wait reads/writes and a two-cycle ERROR response for illegal transfers.
module ahb_sync_sram
    import ahb_defs::*;
#(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 32,
    parameter int DEPTH  = 4096,
    localparam int W_SRAM_ADDR = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ahbls_hready,
    output logic                   ahbls_hready_resp,
    output logic                   ahbls_hresp,
    input  logic                   ahbls_hsel,
    input  logic [W_ADDR-1:0]      ahbls_haddr,
    input  logic                   ahbls_hwrite,
    input  logic [1:0]             ahbls_htrans,
    input  logic [2:0]             ahbls_hsize,
    input  logic [2:0]             ahbls_hburst,
    input  logic [3:0]             ahbls_hprot,
    input  logic                   ahbls_hmastlock,
    input  logic [W_DATA-1:0]      ahbls_hwdata,
    output logic [W_DATA-1:0]      ahbls_hrdata,
    output logic [W_SRAM_ADDR-1:0] sram_addr,
    output logic [W_DATA-1:0]      sram_wdata,
    output logic [W_DATA/8-1:0]    sram_wbyte_en,
    output logic                   sram_wen,
    output logic                   sram_ren,
    input  logic [W_DATA-1:0]      sram_rdata
);

    err_state_t               state_q;
    logic                     hready_resp_q, hresp_q;
    logic                     wr_pend_q, rd_pend_q;
    logic [W_SRAM_ADDR-1:0]   wr_addr_q, rd_addr_q;
    logic [W_DATA/8-1:0]      wr_mask_q;

    logic                     trans_active, accept, illegal, acc_rd, acc_wr;
    logic [W_DATA/8-1:0]      hmask;
    logic [W_SRAM_ADDR-1:0]   haddr_word;
    logic                     wb_valid, wb_load, wb_drain;
    logic [W_SRAM_ADDR-1:0]   wb_addr;
    logic [W_DATA/8-1:0]      wb_mask;
    logic [W_DATA-1:0]        wb_data, merged;

    logic unused_ok;
    assign unused_ok = ^{ahbls_haddr[W_ADDR-1:W_SRAM_ADDR+2], ahbls_hburst,
                         ahbls_hprot, ahbls_hmastlock};

    assign haddr_word = ahbls_haddr[W_SRAM_ADDR+1:2];

    // Transfer-type decode: only NSEQ/SEQ carry a real address phase
    always_comb begin
        case (ahbls_htrans)
            HTRANS_NSEQ, HTRANS_SEQ:  trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY: trans_active = 1'b0;
            default:                  trans_active = 1'b0;
        endcase
    end

    // Byte-lane mask and legality from size and low address bits
    always_comb begin
        hmask   = '0;
        illegal = 1'b0;
        case (ahbls_hsize)
            HSIZE_BYTE: hmask = 4'b0001 << ahbls_haddr[1:0];
            HSIZE_HALF: begin
                hmask   = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
                illegal = ahbls_haddr[0];
            end
            HSIZE_WORD: begin
                hmask   = '1;
                illegal = |ahbls_haddr[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // While HREADYOUT is low (ERR1) address phases are not taken
    assign accept = ahbls_hsel & trans_active & ahbls_hready & (state_q != ST_ERR1);
    assign acc_rd = accept & ~illegal & ~ahbls_hwrite;
    assign acc_wr = accept & ~illegal & ahbls_hwrite;

    // A write data phase colliding with a read address phase is parked;
    // any cycle without a read address phase frees the port for a drain.
    assign wb_load  = wr_pend_q & acc_rd;
    assign wb_drain = wb_valid & ~acc_rd;

    ahb_sram_wbuf #(
        .W_DATA (W_DATA),
        .W_ADDR (W_SRAM_ADDR)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .load_i    (wb_load),
        .drain_i   (wb_drain),
        .addr_i    (wr_addr_q),
        .mask_i    (wr_mask_q),
        .data_i    (ahbls_hwdata),
        .valid_o   (wb_valid),
        .addr_o    (wb_addr),
        .mask_o    (wb_mask),
        .data_o    (wb_data),
        .rd_addr_i (rd_addr_q),
        .rd_data_i (sram_rdata),
        .merged_o  (merged)
    );

    // Error-response FSM with registered HREADYOUT/HRESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_OK;
            hready_resp_q <= 1'b1;
            hresp_q       <= HRESP_OKAY;
        end else begin
            case (state_q)
                ST_ERR1: begin
                    state_q       <= ST_ERR2;
                    hready_resp_q <= 1'b1;
                    hresp_q       <= HRESP_ERROR;
                end
                default: begin
                    if (accept && illegal) begin
                        state_q       <= ST_ERR1;
                        hready_resp_q <= 1'b0;
                        hresp_q       <= HRESP_ERROR;
                    end else begin
                        state_q       <= ST_OK;
                        hready_resp_q <= 1'b1;
                        hresp_q       <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Address-phase capture for the following data phase
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_mask_q <= '0;
            rd_addr_q <= '0;
        end else begin
            wr_pend_q <= acc_wr;
            rd_pend_q <= acc_rd;
            if (acc_wr) begin
                wr_addr_q <= haddr_word;
                wr_mask_q <= hmask;
            end
            if (acc_rd) rd_addr_q <= haddr_word;
        end
    end

    // SRAM port: read address phase first, then direct write, then drain
    always_comb begin
        sram_ren      = acc_rd & ~rst;
        sram_wen      = (wr_pend_q | wb_valid) & ~acc_rd & ~rst;
        sram_addr     = wb_addr;
        sram_wdata    = wb_data;
        sram_wbyte_en = wb_mask;
        if (acc_rd) begin
            sram_addr = haddr_word;
        end else if (wr_pend_q) begin
            sram_addr     = wr_addr_q;
            sram_wdata    = ahbls_hwdata;
            sram_wbyte_en = wr_mask_q;
        end
    end

    assign ahbls_hready_resp = hready_resp_q;
    assign ahbls_hresp       = hresp_q;
    assign ahbls_hrdata      = rd_pend_q ? merged : '0;

    // The write address cycle took no read, so the buffer drained then
    assert property (@(posedge clk) disable iff (rst) wr_pend_q |-> !wb_valid);

endmodule

// File: tb/tb_ahb_sync_sram.sv
// Self-checking bench for ahb_sync_sram: behavioural memory model plus
// directed literal checks and a randomized traffic phase.
module tb_ahb_sync_sram;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        hready, hsel, hwrite, hmastlock;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hready_resp, hresp;
    logic [31:0] hrdata;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [3:0]  sram_wbyte_en;
    logic        sram_wen, sram_ren;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ahb_sync_sram #(.W_DATA(32), .W_ADDR(32), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready      (hready),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hresp       (hresp),
        .ahbls_hsel        (hsel),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hburst      (hburst),
        .ahbls_hprot       (hprot),
        .ahbls_hmastlock   (hmastlock),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_wbyte_en     (sram_wbyte_en),
        .sram_wen          (sram_wen),
        .sram_ren          (sram_ren),
        .sram_rdata        (sram_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- SRAM behavioural macro ----------------
    logic [31:0] mem [DEPTH];

    always @(posedge clk) begin
        if (sram_wen)
            for (int i = 0; i < 4; i++)
                if (sram_wbyte_en[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        if (sram_ren) sram_rdata <= mem[sram_addr];
        else          sram_rdata <= $urandom;
    end

    // ---------------- reference model ----------------
    // ref_mem holds committed contents; one pending write (m_pv) is visible to
    // reads but is only committed in a cycle with no accepted read, and is
    // lost on reset.
    logic [31:0] ref_mem [DEPTH];
    int          m_err = 0;
    bit          m_rd = 0, m_wr = 0, m_pv = 0;
    int unsigned m_ra, m_wa, m_pw;
    logic [3:0]  m_wm, m_pm;
    logic [31:0] m_pd;

    function automatic bit legal(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [3:0] maskof(input logic [2:0] sz, input logic [31:0] a);
        logic [3:0] m;
        int unsigned lo, n;
        lo = a % 4;
        n  = 1 << sz;
        for (int i = 0; i < 4; i++) m[i] = (i >= lo) && (i < lo + n);
        return m;
    endfunction

    function automatic int unsigned wordof(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic logic [31:0] exp_word(input int unsigned w);
        logic [31:0] v;
        v = ref_mem[w];
        if (m_pv && m_pw == w)
            for (int i = 0; i < 4; i++) if (m_pm[i]) v[8*i +: 8] = m_pd[8*i +: 8];
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit acc, lg, rd_acc;
        if (rst) begin
            m_err = 0; m_rd = 0; m_wr = 0; m_pv = 0;
        end else begin
            if (m_wr) begin
                m_pv = 1; m_pw = m_wa; m_pm = m_wm; m_pd = hwdata;
            end
            acc    = hsel && htrans[1] && hready && (m_err != 1);
            lg     = legal(hsize, haddr);
            rd_acc = acc && lg && !hwrite;
            if (m_pv && !rd_acc) begin
                for (int i = 0; i < 4; i++)
                    if (m_pm[i]) ref_mem[m_pw][8*i +: 8] = m_pd[8*i +: 8];
                m_pv = 0;
            end
            m_err = (m_err == 1) ? 2 : 0;
            if (acc && !lg) m_err = 1;
            m_rd = rd_acc;
            m_ra = wordof(haddr);
            m_wr = acc && lg && hwrite;
            m_wa = wordof(haddr);
            m_wm = maskof(hsize, haddr);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit acc, exp_ren;
        if (chk_en) begin
            check("hready_resp", {31'd0, hready_resp}, {31'd0, m_err != 1});
            check("hresp", {31'd0, hresp}, {31'd0, m_err != 0});
            check("hrdata", hrdata, m_rd ? exp_word(m_ra) : 32'd0);
            acc     = hsel && htrans[1] && hready && (m_err != 1);
            exp_ren = !rst && acc && !hwrite && legal(hsize, haddr);
            check("sram_ren", {31'd0, sram_ren}, {31'd0, exp_ren});
            if (exp_ren) check("sram_addr", {20'd0, sram_addr}, wordof(haddr));
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] pend_wd = 32'd0;

    task automatic do_cycle(input bit sel, input logic [1:0] tr, input bit wr,
                            input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd, input bit rdy);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        hsel      = sel;
        htrans    = tr;
        hwrite    = wr;
        haddr     = a;
        hsize     = sz;
        hready    = rdy;
        hburst    = 3'($urandom);
        hprot     = 4'($urandom);
        hmastlock = 1'($urandom);
        hwdata    = pend_wd;
        pend_wd   = wr ? wd : $urandom;
    endtask

    task automatic idle();
        do_cycle(1'b0, 2'b00, 1'b0, $urandom, 3'd2, 32'd0, 1'b1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        do_cycle(1'b1, 2'b10, 1'b1, a, sz, d, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz);
        do_cycle(1'b1, 2'b10, 1'b0, a, sz, 32'd0, 1'b1);
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = $urandom;
    endtask

    initial begin
        logic [31:0] d [3];
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst = 1'b1; hsel = 0; htrans = 0; hwrite = 0; haddr = 0; hsize = 0;
        hready = 1; hburst = 0; hprot = 0; hmastlock = 0; hwdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_hready", {31'd0, hready_resp}, 32'd1);
        check("rst_hresp", {31'd0, hresp}, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_wen", {31'd0, sram_wen}, 32'd0);
        check("rst_ren", {31'd0, sram_ren}, 32'd0);

        // Write, gap, read back
        wr(32'h10, 3'd2, 32'hDEADBEEF);
        idle();
        rd(32'h10, 3'd2);
        idle();
        @(negedge clk);
        check("wr_rd_basic", hrdata, 32'hDEADBEEF);

        // Back-to-back write/read: forwarding, then drain in the next idle cycle
        wr(32'h20, 3'd2, 32'h11223344);
        rd(32'h20, 3'd2);
        idle();
        @(negedge clk);
        check("raw_fwd", hrdata, 32'h11223344);
        check("drain_wen", {31'd0, sram_wen}, 32'd1);
        check("drain_addr", {20'd0, sram_addr}, 32'h8);
        check("drain_be", {28'd0, sram_wbyte_en}, 32'hF);
        idle();

        // Byte write into a word of all ones
        wr(32'h30, 3'd2, 32'hFFFFFFFF);
        wr(32'h31, 3'd0, 32'h0000AB00);
        idle();
        @(negedge clk);
        check("byte_wen", {31'd0, sram_wen}, 32'd1);
        check("byte_be", {28'd0, sram_wbyte_en}, 32'h2);
        check("byte_addr", {20'd0, sram_addr}, 32'hC);
        rd(32'h30, 3'd2);
        idle();
        @(negedge clk);
        check("byte_merge", hrdata, 32'hFFFFABFF);

        // W,R,W,R,W,R to distinct addresses, then read everything back
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            wr(32'h100 + 8 * i, 3'd2, d[i]);
            rd(32'h104 + 8 * i, 3'd2);
        end
        rd(32'h100, 3'd2);
        rd(32'h108, 3'd2);
        @(negedge clk);
        check("wr_pat0", hrdata, d[0]);
        rd(32'h110, 3'd2);
        @(negedge clk);
        check("wr_pat1", hrdata, d[1]);
        idle();
        @(negedge clk);
        check("wr_pat2", hrdata, d[2]);
        idle();

        // Misaligned word -> ERR1, ERR2; read issued in ERR2 completes OKAY
        rd(32'h42, 3'd2);
        rd(32'h80, 3'd2);
        @(negedge clk);
        check("err1_hready", {31'd0, hready_resp}, 32'd0);
        check("err1_hresp", {31'd0, hresp}, 32'd1);
        check("err1_wen", {31'd0, sram_wen}, 32'd0);
        check("err1_ren", {31'd0, sram_ren}, 32'd0);
        rd(32'h10, 3'd2);
        @(negedge clk);
        check("err2_hready", {31'd0, hready_resp}, 32'd1);
        check("err2_hresp", {31'd0, hresp}, 32'd1);
        check("err2_ren", {31'd0, sram_ren}, 32'd1);
        idle();
        @(negedge clk);
        check("post_err_hresp", {31'd0, hresp}, 32'd0);
        check("post_err_data", hrdata, 32'hDEADBEEF);

        // Reset while the buffer holds a write: that write is lost
        wr(32'h50, 3'd2, 32'hCAFEF00D);
        idle();
        wr(32'h50, 3'd2, 32'h12345678);
        rd(32'h54, 3'd2);
        reset_cycle();
        @(negedge clk);
        check("rst_cycle_wen", {31'd0, sram_wen}, 32'd0);
        idle();
        @(negedge clk);
        check("rst2_hready", {31'd0, hready_resp}, 32'd1);
        check("rst2_hresp", {31'd0, hresp}, 32'd0);
        check("rst2_hrdata", hrdata, 32'd0);
        check("rst2_wen", {31'd0, sram_wen}, 32'd0);
        check("rst2_ren", {31'd0, sram_ren}, 32'd0);
        rd(32'h50, 3'd2);
        idle();
        @(negedge clk);
        check("rst_lost_wr", hrdata, 32'hCAFEF00D);

        // Randomized traffic over a small window, with upper-bit aliasing
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            if ($urandom_range(0, 199) == 0) begin
                reset_cycle();
            end else begin
                sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                a  = {2'($urandom), 16'd0, 12'($urandom_range(0, 31)), 2'd0};
                a[15:14] = 2'($urandom);
                if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
                else if (sz == 3'd0) a[1:0] = 2'($urandom);
                else if (sz == 3'd1) a[1] = 1'($urandom);
                do_cycle($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), a, sz,
                         $urandom, $urandom_range(0, 9) != 0);
            end
        end
        idle();
        idle();
        idle();
        for (int w = 0; w < 32; w++) rd(32'(w * 4), 3'd2);
        idle();
        idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sync_sram.md
Name: ahb_sync_sram

Overview:
- AHB-lite slave fronting a single-port synchronous SRAM (1-cycle read latency); serves the CPU's AHB-lite master port as on-chip instruction/data memory.
- Zero-wait-state reads and writes via a one-entry write buffer with read-after-write forwarding.
- Illegal transfers (oversize, misaligned) get a two-cycle ERROR response.

Parameters:
- W_DATA, 32, bus and SRAM data width (fixed 32; byte lanes = 4)
- W_ADDR, 32, AHB address width
- DEPTH, 4096, SRAM depth in words; W_SRAM_ADDR = $clog2(DEPTH) (localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ahbls_hready  in  1  bus-wide HREADY (previous data phase completing)
- ahbls_hready_resp  out  1  this slave's HREADYOUT
- ahbls_hresp  out  1  0 OKAY, 1 ERROR
- ahbls_hsel  in  1  slave select
- ahbls_haddr  in  W_ADDR  address
- ahbls_hwrite  in  1  write when 1
- ahbls_htrans  in  2  IDLE/BUSY/NSEQ/SEQ
- ahbls_hsize  in  3  transfer size
- ahbls_hburst  in  3  ignored
- ahbls_hprot  in  4  ignored
- ahbls_hmastlock  in  1  ignored
- ahbls_hwdata  in  W_DATA  write data (data phase)
- ahbls_hrdata  out  W_DATA  read data (data phase)
- sram_addr  out  W_SRAM_ADDR  word address
- sram_wdata  out  W_DATA  write data
- sram_wbyte_en  out  W_DATA/8  byte write enables
- sram_wen  out  1  write strobe
- sram_ren  out  1  read strobe
- sram_rdata  in  W_DATA  read data, valid cycle after sram_ren

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset: hready_resp=1, hresp=0, hrdata=0, sram_wen=0, sram_ren=0, write buffer empty, FSM=OK. Reset mid-transfer discards pending write and any error sequence.
- Accept: valid = hsel & htrans[1] & hready. BUSY/IDLE or unselected: OKAY, zero wait, no SRAM access.
- Word address = haddr[W_SRAM_ADDR+1:2]; upper bits ignored (aliasing).
- Byte mask: hsize 0 -> lane haddr[1:0]; hsize 1 -> lanes {haddr[1],x}; hsize 2 -> 4'hf.
- Illegal: hsize>2, hsize=1 & haddr[0], or hsize=2 & haddr[1:0]!=0. No SRAM access.
- FSM OK/ERR1/ERR2:
  - Illegal accepted -> ERR1 (hready_resp=0, hresp=1) -> ERR2 (hready_resp=1, hresp=1) -> OK.
  - Address phases presented during ERR1 are ignored (hready low). An address phase in ERR2 is accepted normally.
- Read: in the address-phase cycle, drive sram_ren=1 and sram_addr. Next cycle (data phase), hrdata = merge(sram_rdata, buffer), OKAY, no wait. Outside read data phases hrdata=0.
- Write address phase: register word address and byte mask. The data phase follows next cycle:
  - If no read is accepted that cycle, write hwdata directly: sram_wen=1, sram_wbyte_en=mask.
  - Otherwise load the buffer {addr, mask, hwdata}, wb_valid=1.
- Drain: any cycle with wb_valid=1 and no read accepted -> sram_wen=1 from buffer, wb_valid=0 next cycle.
- Priority: a read address phase owns the SRAM port. A direct write and a drain never coincide.
- Invariant (assert): wb_valid=0 whenever a write data phase begins. The preceding write address cycle accepted no read, so the buffer drained then. One entry therefore never overflows.
- Forwarding: in a read data phase, if wb_valid & wb_addr==rd_addr_q, take hrdata lanes from the buffer where mask=1, otherwise from sram_rdata. This uses the current wb_valid; a drain in the same cycle does not affect it.
- Read-after-write to the same address with no gap returns the new data.
- Write data lanes outside the mask are never written.

Decomposition:
- Shared package ahb_defs: HTRANS_IDLE/BUSY/NSEQ/SEQ, HSIZE_BYTE/HALF/WORD, HRESP_OKAY/ERROR.
- One sub-module, ahb_sram_wbuf: the one-entry write buffer holding valid/addr/mask/data, with load, drain and forward-merge logic.
- FSM and byte-mask decode stay in the top level.

Test Plan:
- Reset, then NSEQ write word 0x0000_0010 = 0xDEADBEEF, idle, read 0x10 -> read data phase OKAY, hrdata=0xDEADBEEF, zero wait states throughout.
- Back-to-back W(0x20, 0x11223344, word) then R(0x20) -> buffer loaded, hrdata=0x11223344 via forwarding; drain seen with sram_wen=1, addr=0x8 in the following idle cycle.
- Byte write 0xAB to 0x31 (hwdata=0x0000AB00), then word read 0x30 over prior 0xFFFFFFFF -> sram_wbyte_en=4'b0010, hrdata=0xFFFFABFF.
- Pattern W,R,W,R,W,R to distinct addresses with random data, then read all back -> all values match, buffer-overflow assertion never fires.
- Word access at 0x42 -> ERR1 (hready_resp=0, hresp=1), ERR2 (1,1), no sram_wen/sram_ren. A read issued in the ERR2 cycle completes OKAY next cycle.
- Assert rst for one cycle with buffer full -> outputs return to reset values next cycle, no sram_wen, and the pending write is lost (readback shows old data).
